// File: rtl/mmu_byte_port.sv
// mmu_byte_port: serves MEM word reads and masked writes as four byte beats on a byte-wide synchronous RAM
module mmu_byte_port #(
  parameter int ADDR_W = 17
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [31:0]       i_MEM_raddr,
  output logic [31:0]       o_MEM_raddr,
  output logic [31:0]       o_MEM_rdata_raw,
  output logic              o_MEM_rbusy,
  input  logic [31:0]       i_MEM_waddr,
  input  logic [3:0]        i_MEM_wmask_raw,
  input  logic [31:0]       i_MEM_wdata_raw,
  output logic [31:0]       o_MEM_waddr,
  output logic              o_MEM_wbusy,
  output logic [ADDR_W-1:0] o_RAM_addr,
  output logic              o_RAM_we,
  output logic [7:0]        o_RAM_wdata,
  input  logic [7:0]        i_RAM_rdata
);
  localparam logic [1:0] IDLE = 2'd0, RD = 2'd1, WR = 2'd2;
  logic [1:0]        st_q, st_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [31:0]       addr_q, addr_d, raddr_q, raddr_d, waddr_q, waddr_d, rdata_q, rdata_d;
  logic [23:0]       wsh_q, wsh_d, rsh_q, rsh_d;
  logic [2:0]        msk_q, msk_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic              we_q, we_d;
  logic [7:0]        wbyte_q, wbyte_d;
  logic              rd_pend, wr_pend;
  // next-state: the first beat is launched on leaving IDLE, later lanes are shifted out/in each beat
  always_comb begin
    st_d       = st_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    raddr_d    = raddr_q;
    waddr_d    = waddr_q;
    rdata_d    = rdata_q;
    wsh_d      = wsh_q;
    rsh_d      = rsh_q;
    msk_d      = msk_q;
    ram_addr_d = ram_addr_q;
    we_d       = we_q;
    wbyte_d    = wbyte_q;
    rd_pend    = (i_MEM_raddr != raddr_q) && (i_MEM_raddr[1:0] == 2'b00);
    wr_pend    = (i_MEM_waddr != waddr_q) && (i_MEM_waddr[1:0] == 2'b00);
    case (st_q)
      IDLE: begin
        cnt_d = 3'd0;
        if (wr_pend) begin
          st_d       = WR;
          addr_d     = i_MEM_waddr;
          wsh_d      = i_MEM_wdata_raw[23:0];
          msk_d      = i_MEM_wmask_raw[2:0];
          ram_addr_d = i_MEM_waddr[ADDR_W-1:0];
          we_d       = i_MEM_wmask_raw[3];
          wbyte_d    = i_MEM_wdata_raw[31:24];
        end else if (rd_pend) begin
          st_d       = RD;
          addr_d     = i_MEM_raddr;
          ram_addr_d = i_MEM_raddr[ADDR_W-1:0];
        end
      end
      RD: begin
        cnt_d = cnt_q + 3'd1;
        if (cnt_q < 3'd3) ram_addr_d = {addr_q[ADDR_W-1:2], cnt_q[1:0] + 2'd1};
        if (cnt_q != 3'd0) rsh_d = {rsh_q[15:0], i_RAM_rdata};
        if (cnt_q == 3'd4) begin
          rdata_d = {rsh_q, i_RAM_rdata};
          raddr_d = addr_q;
          st_d    = IDLE;
          cnt_d   = 3'd0;
        end
      end
      WR: begin
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'd3) begin
          we_d    = 1'b0;
          waddr_d = addr_q;
          st_d    = IDLE;
          cnt_d   = 3'd0;
        end else begin
          ram_addr_d = {addr_q[ADDR_W-1:2], cnt_q[1:0] + 2'd1};
          we_d       = msk_q[2];
          wbyte_d    = wsh_q[23:16];
          wsh_d      = {wsh_q[15:0], 8'h00};
          msk_d      = {msk_q[1:0], 1'b0};
        end
      end
      default: st_d = IDLE;
    endcase
  end
  // state and registered outputs; reset abandons any transaction in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q       <= IDLE;
      cnt_q      <= 3'd0;
      addr_q     <= 32'h0;
      raddr_q    <= 32'hFFFF_FFFF;
      waddr_q    <= 32'hFFFF_FFFF;
      rdata_q    <= 32'h0;
      wsh_q      <= 24'h0;
      rsh_q      <= 24'h0;
      msk_q      <= 3'b0;
      ram_addr_q <= '0;
      we_q       <= 1'b0;
      wbyte_q    <= 8'h0;
    end else begin
      st_q       <= st_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      raddr_q    <= raddr_d;
      waddr_q    <= waddr_d;
      rdata_q    <= rdata_d;
      wsh_q      <= wsh_d;
      rsh_q      <= rsh_d;
      msk_q      <= msk_d;
      ram_addr_q <= ram_addr_d;
      we_q       <= we_d;
      wbyte_q    <= wbyte_d;
    end
  end
  assign o_MEM_raddr     = raddr_q;
  assign o_MEM_waddr     = waddr_q;
  assign o_MEM_rdata_raw = rdata_q;
  assign o_MEM_rbusy     = st_q == RD;
  assign o_MEM_wbusy     = st_q == WR;
  assign o_RAM_addr      = ram_addr_q;
  assign o_RAM_we        = we_q;
  assign o_RAM_wdata     = wbyte_q;
endmodule

// File: tb/tb_mmu_byte_port.sv
// tb_mmu_byte_port: directed vectors against a behavioural byte RAM
module tb_mmu_byte_port;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] i_MEM_raddr = 32'hFFFF_FFFF, i_MEM_waddr = 32'hFFFF_FFFF;
  logic [3:0]  i_MEM_wmask_raw = 4'h0;
  logic [31:0] i_MEM_wdata_raw = 32'h0;
  logic [31:0] o_MEM_raddr, o_MEM_rdata_raw, o_MEM_waddr;
  logic        o_MEM_rbusy, o_MEM_wbusy, o_RAM_we;
  logic [16:0] o_RAM_addr;
  logic [7:0]  o_RAM_wdata, i_RAM_rdata;
  logic [7:0]  mem [0:131071];
  logic        tb_we = 1'b0;
  logic [16:0] tb_a = '0;
  logic [7:0]  tb_d = '0;
  int          nvec = 0, nerr = 0;

  mmu_byte_port #(.ADDR_W(17)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_MEM_raddr(i_MEM_raddr), .o_MEM_raddr(o_MEM_raddr), .o_MEM_rdata_raw(o_MEM_rdata_raw),
    .o_MEM_rbusy(o_MEM_rbusy), .i_MEM_waddr(i_MEM_waddr), .i_MEM_wmask_raw(i_MEM_wmask_raw),
    .i_MEM_wdata_raw(i_MEM_wdata_raw), .o_MEM_waddr(o_MEM_waddr), .o_MEM_wbusy(o_MEM_wbusy),
    .o_RAM_addr(o_RAM_addr), .o_RAM_we(o_RAM_we), .o_RAM_wdata(o_RAM_wdata), .i_RAM_rdata(i_RAM_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (tb_we) mem[tb_a] <= tb_d;
    else if (o_RAM_we) mem[o_RAM_addr] <= o_RAM_wdata;
    i_RAM_rdata <= mem[o_RAM_addr];
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic poke(input logic [16:0] a, input logic [7:0] d);
    tb_a = a; tb_d = d; tb_we = 1'b1;
    step(1);
    tb_we = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    step(1);
    for (int i = 0; i < 4; i++) begin
      poke(17'h100 + 17'(i), 8'h11 * 8'(i + 1));
      poke(17'h104 + 17'(i), 8'h55 + 8'h11 * 8'(i));
      poke(17'h200 + 17'(i), 8'h00);
      poke(17'h300 + 17'(i), 8'h00);
    end
    chk("rst_raddr", o_MEM_raddr, 32'hFFFF_FFFF);
    chk("rst_waddr", o_MEM_waddr, 32'hFFFF_FFFF);
    chk("rst_rbusy", {31'b0, o_MEM_rbusy}, 32'h0);
    chk("rst_wbusy", {31'b0, o_MEM_wbusy}, 32'h0);
    chk("rst_we", {31'b0, o_RAM_we}, 32'h0);
    chk("rst_ramaddr", {15'b0, o_RAM_addr}, 32'h0);
    chk("rst_rdata", o_MEM_rdata_raw, 32'h0);
    rst_n = 1'b1;
    step(2);
    i_MEM_raddr = 32'h101;
    step(3);
    chk("mis_rbusy", {31'b0, o_MEM_rbusy}, 32'h0);
    chk("mis_raddr", o_MEM_raddr, 32'hFFFF_FFFF);
    chk("mis_ramaddr", {15'b0, o_RAM_addr}, 32'h0);
    i_MEM_raddr = 32'h100;
    for (int k = 0; k < 4; k++) begin
      step(1);
      chk("rd_busy", {31'b0, o_MEM_rbusy}, 32'h1);
      chk("rd_ramaddr", {15'b0, o_RAM_addr}, 32'h100 + k);
      chk("rd_we", {31'b0, o_RAM_we}, 32'h0);
    end
    step(1);
    chk("rd_t5_busy", {31'b0, o_MEM_rbusy}, 32'h1);
    chk("rd_t5_echo", o_MEM_raddr, 32'hFFFF_FFFF);
    step(1);
    chk("rd_data", o_MEM_rdata_raw, 32'h1122_3344);
    chk("rd_echo", o_MEM_raddr, 32'h100);
    chk("rd_done", {31'b0, o_MEM_rbusy}, 32'h0);
    step(2);
    chk("rd_norepeat", {31'b0, o_MEM_rbusy}, 32'h0);
    i_MEM_waddr = 32'h200; i_MEM_wmask_raw = 4'b0100; i_MEM_wdata_raw = 32'h00AB_0000;
    for (int k = 0; k < 4; k++) begin
      step(1);
      chk("wr_busy", {31'b0, o_MEM_wbusy}, 32'h1);
      chk("wr_ramaddr", {15'b0, o_RAM_addr}, 32'h200 + k);
      chk("wr_we", {31'b0, o_RAM_we}, (k == 1) ? 32'h1 : 32'h0);
      if (k == 1) chk("wr_byte", {24'b0, o_RAM_wdata}, 32'hAB);
    end
    step(1);
    chk("wr_echo", o_MEM_waddr, 32'h200);
    chk("wr_done", {31'b0, o_MEM_wbusy}, 32'h0);
    chk("wr_we_off", {31'b0, o_RAM_we}, 32'h0);
    i_MEM_raddr = 32'h200;
    step(6);
    chk("rdback_data", o_MEM_rdata_raw, 32'h00AB_0000);
    chk("rdback_echo", o_MEM_raddr, 32'h200);
    i_MEM_waddr = 32'h300; i_MEM_wmask_raw = 4'b1111; i_MEM_wdata_raw = 32'hDEAD_BEEF;
    i_MEM_raddr = 32'h300;
    step(1);
    chk("sim_wbusy", {31'b0, o_MEM_wbusy}, 32'h1);
    chk("sim_rbusy", {31'b0, o_MEM_rbusy}, 32'h0);
    step(4);
    chk("sim_wecho", o_MEM_waddr, 32'h300);
    chk("sim_recho_t5", o_MEM_raddr, 32'h200);
    step(1);
    chk("sim_rbusy_t6", {31'b0, o_MEM_rbusy}, 32'h1);
    step(4);
    chk("sim_recho_t10", o_MEM_raddr, 32'h200);
    step(1);
    chk("sim_rdata", o_MEM_rdata_raw, 32'hDEAD_BEEF);
    chk("sim_recho", o_MEM_raddr, 32'h300);
    i_MEM_raddr = 32'h100;
    step(3);
    i_MEM_raddr = 32'h104;
    step(3);
    chk("chg_echo1", o_MEM_raddr, 32'h100);
    chk("chg_data1", o_MEM_rdata_raw, 32'h1122_3344);
    step(1);
    chk("chg_ramaddr", {15'b0, o_RAM_addr}, 32'h104);
    step(5);
    chk("chg_echo2", o_MEM_raddr, 32'h104);
    chk("chg_data2", o_MEM_rdata_raw, 32'h5566_7788);
    i_MEM_waddr = 32'h204; i_MEM_wmask_raw = 4'b1111; i_MEM_wdata_raw = 32'h0102_0304;
    step(3);
    chk("mid_we", {31'b0, o_RAM_we}, 32'h1);
    chk("mid_ramaddr", {15'b0, o_RAM_addr}, 32'h206);
    rst_n = 1'b0;
    #1;
    chk("mid_we_drop", {31'b0, o_RAM_we}, 32'h0);
    chk("mid_wbusy", {31'b0, o_MEM_wbusy}, 32'h0);
    chk("mid_waddr", o_MEM_waddr, 32'hFFFF_FFFF);
    chk("mid_raddr", o_MEM_raddr, 32'hFFFF_FFFF);
    step(1);
    rst_n = 1'b1;
    step(5);
    chk("mid_retry_echo", o_MEM_waddr, 32'h204);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
